// File: rtl/lc3b_mc_alu_if.sv
// Request/response handshake bundle for lc3b_mc_alu.
// master = requester/consumer side, slave = the ALU.
interface lc3b_mc_alu_if #(
    parameter int WIDTH = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic [2:0]       resp_nzp;
    logic             busy;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_nzp, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data, resp_nzp, busy
    );
endinterface

// File: rtl/lc3b_mc_alu.sv
// Multi-cycle LC-3b ALU with held response and nzp codes.
// Define LC3B_ALU_MUL_EN to build the iterative shift-add multiply (op 7).
module lc3b_mc_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic         clk,
    input  logic         rst,
    lc3b_mc_alu_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DONE = 2'd1
`ifdef LC3B_ALU_MUL_EN
        , S_MUL = 2'd2
`endif
    } state_t;

    state_t           r_state;
    state_t           w_next;
    state_t           w_tgt;
    logic             w_accept;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] r_data;
    logic [2:0]       r_nzp;

    function automatic logic [2:0] f_nzp(input logic [WIDTH-1:0] d);
        if (d[WIDTH-1])     return 3'b100;
        else if (d == '0)   return 3'b010;
        else                return 3'b001;
    endfunction

    assign w_sh = bus.req_b[SHW-1:0];
    assign bus.req_ready  = (r_state == S_IDLE) ||
                            ((r_state == S_DONE) && bus.resp_ready);
    assign bus.resp_valid = (r_state == S_DONE);
    assign bus.resp_data  = r_data;
    assign bus.resp_nzp   = r_nzp;
    assign w_accept       = bus.req_valid && bus.req_ready;

    always_comb begin
        w_alu = bus.req_a;
        case (bus.req_op)
            4'd0:    w_alu = bus.req_a + bus.req_b;
            4'd1:    w_alu = bus.req_a & bus.req_b;
            4'd2:    w_alu = ~bus.req_a;
            4'd4:    w_alu = bus.req_a << w_sh;
            4'd5:    w_alu = bus.req_a >> w_sh;
            4'd6:    w_alu = WIDTH'($signed(bus.req_a) >>> w_sh);
            default: w_alu = bus.req_a;
        endcase
    end

`ifdef LC3B_ALU_MUL_EN
    logic             w_is_mul;
    logic             w_last;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [SHW-1:0]   r_cnt;

    assign w_is_mul = (bus.req_op == 4'd7);
    assign w_sum    = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_last   = (r_state == S_MUL) && (r_cnt == SHW'(WIDTH - 1));
    assign bus.busy = (r_state == S_MUL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (w_accept && w_is_mul) begin
            r_acc    <= '0;
            r_mcand  <= bus.req_a;
            r_mplier <= bus.req_b;
            r_cnt    <= '0;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end
`else
    assign bus.busy = 1'b0;
`endif

    always_comb begin
        w_tgt = S_DONE;
`ifdef LC3B_ALU_MUL_EN
        if (w_is_mul) w_tgt = S_MUL;
`endif
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_tgt;
            S_DONE: begin
                // A consumed response may chain straight into the next op.
                if (bus.resp_ready) w_next = w_accept ? w_tgt : S_IDLE;
            end
`ifdef LC3B_ALU_MUL_EN
            S_MUL:  if (w_last) w_next = S_DONE;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_nzp  <= 3'b010;
`ifdef LC3B_ALU_MUL_EN
        end else if (w_accept && !w_is_mul) begin
            r_data <= w_alu;
            r_nzp  <= f_nzp(w_alu);
        end else if (w_last) begin
            r_data <= w_sum;
            r_nzp  <= f_nzp(w_sum);
`else
        end else if (w_accept) begin
            r_data <= w_alu;
            r_nzp  <= f_nzp(w_alu);
`endif
        end
    end
endmodule

// File: tb/tb_lc3b_mc_alu.sv
// Self-checking bench for lc3b_mc_alu: vector table, random ops vs model,
// and hand sequences for streaming, backpressure, multiply and reset.
module tb_lc3b_mc_alu;
    localparam int W = 16;
    localparam bit MUL_ON =
`ifdef LC3B_ALU_MUL_EN
        1'b1;
`else
        1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lc3b_mc_alu_if #(.WIDTH(W)) bus ();
    lc3b_mc_alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_res(input logic [3:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int unsigned sh;
        int sa;
        sh = int'(b) % W;
        sa = int'($signed(a));
        case (op)
            4'd0: return W'(int'(a) + int'(b));
            4'd1: return a & b;
            4'd2: return ~a;
            4'd4: return W'(int'(a) * (1 << sh));
            4'd5: return W'(int'(a) / (1 << sh));
            4'd6: return W'(sa >>> sh);
            4'd7: return MUL_ON ? W'(longint'(a) * longint'(b)) : a;
            default: return a;
        endcase
    endfunction

    function automatic logic [2:0] ref_nzp(input logic [W-1:0] d);
        if ($signed(d) < 0) return 3'b100;
        if (d == 0)         return 3'b010;
        return 3'b001;
    endfunction

    function automatic int ref_lat(input logic [3:0] op);
        return (MUL_ON && op == 4'd7) ? W + 1 : 1;
    endfunction

    // Issue one op with resp_ready high; lat = negedges from accept to valid.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, output logic [W-1:0] d,
                          output logic [2:0] nzp, output int lat);
        int k;
        d = '0; nzp = '0; lat = -1;
        @(negedge clk);
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b1;
        bus.req_op = op; bus.req_a = a; bus.req_b = b;
        k = 0;
        while (!bus.req_ready && k < 50) begin
            @(negedge clk); k++;
        end
        if (!bus.req_ready) begin
            chk("req_ready_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                lat = i; d = bus.resp_data; nzp = bus.resp_nzp;
                break;
            end
        end
        if (lat < 0) chk("resp_valid_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic [2:0]   nzp;
        int           lat;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [W-1:0] d, ra, rb;
        logic [2:0]   n;
        logic [3:0]   rop;
        int           lat, nb, nrdy, k;

        tbl[0] = '{4'd0, 16'h7FFF, 16'h0001, 16'h8000, 3'b100, 1};
        tbl[1] = '{4'd6, 16'h8010, 16'h0004, 16'hF801, 3'b100, 1};
        tbl[2] = '{4'd5, 16'h8010, 16'h0004, 16'h0801, 3'b001, 1};
        tbl[3] = '{4'd4, 16'h0001, 16'h001F, 16'h8000, 3'b100, 1};
        tbl[4] = '{4'd1, 16'h00F0, 16'h0F0F, 16'h0000, 3'b010, 1};
        tbl[5] = '{4'd2, 16'h0000, 16'h0000, 16'hFFFF, 3'b100, 1};
        tbl[6] = '{4'd3, 16'h0001, 16'h5555, 16'h0001, 3'b001, 1};
        tbl[7] = '{4'd12, 16'h1234, 16'h0000, 16'h1234, 3'b001, 1};
        tbl[8] = '{4'd4, 16'h0005, 16'h0010, 16'h0005, 3'b001, 1};
        if (MUL_ON) tbl[9] = '{4'd7, 16'hFFFD, 16'h0007, 16'hFFEB, 3'b100, W + 1};
        else        tbl[9] = '{4'd7, 16'h1234, 16'h0007, 16'h1234, 3'b001, 1};

        rst = 1'b1;
        bus.req_valid = 1'b0; bus.resp_ready = 1'b0;
        bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data", 32'(bus.resp_data), 32'd0);
        chk("rst_resp_nzp", 32'(bus.resp_nzp), 32'b010);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, d, n, lat);
            chk($sformatf("vec%0d_data", i), 32'(d), 32'(tbl[i].d));
            chk($sformatf("vec%0d_nzp", i), 32'(n), 32'(tbl[i].nzp));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
        end

        // Streaming: two ops on consecutive cycles, no bubble.
        @(negedge clk);
        bus.resp_ready = 1'b1; bus.req_valid = 1'b1;
        bus.req_op = 4'd1; bus.req_a = 16'h00F0; bus.req_b = 16'h0F0F;
        @(posedge clk); #1;
        bus.req_op = 4'd2; bus.req_a = 16'h0000; bus.req_b = 16'h0000;
        @(negedge clk);
        chk("b2b_valid0", 32'(bus.resp_valid), 32'd1);
        chk("b2b_data0", 32'(bus.resp_data), 32'h0000);
        chk("b2b_nzp0", 32'(bus.resp_nzp), 32'b010);
        chk("b2b_ready0", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_valid1", 32'(bus.resp_valid), 32'd1);
        chk("b2b_data1", 32'(bus.resp_data), 32'hFFFF);
        chk("b2b_nzp1", 32'(bus.resp_nzp), 32'b100);

        // Backpressure with a pending request waiting behind it.
        @(negedge clk);
        bus.resp_ready = 1'b0; bus.req_valid = 1'b1;
        bus.req_op = 4'd3; bus.req_a = 16'h00AA; bus.req_b = 16'h0000;
        @(posedge clk); #1;
        bus.req_op = 4'd0; bus.req_a = 16'h0001; bus.req_b = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.resp_valid), 32'd1);
            chk("bp_data", 32'(bus.resp_data), 32'h00AA);
            chk("bp_ready", 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk);
        bus.resp_ready = 1'b1; #1;
        chk("bp_release_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_valid", 32'(bus.resp_valid), 32'd1);
        chk("bp_next_data", 32'(bus.resp_data), 32'h0002);
        chk("bp_next_nzp", 32'(bus.resp_nzp), 32'b001);

        if (MUL_ON) begin
            // Multiply with other requests presented while it iterates.
            @(negedge clk);
            bus.resp_ready = 1'b0; bus.req_valid = 1'b1;
            bus.req_op = 4'd7; bus.req_a = 16'hFFFD; bus.req_b = 16'h0007;
            @(posedge clk); #1;
            bus.req_op = 4'd0; bus.req_a = 16'h0001; bus.req_b = 16'h0001;
            nb = 0; nrdy = 0; k = 0;
            for (int i = 1; i <= 40; i++) begin
                @(negedge clk);
                if (bus.resp_valid) begin k = i; break; end
                if (bus.busy) nb++;
                if (bus.req_ready) nrdy++;
            end
            chk("mul_busy_cycles", 32'(nb), 32'(W));
            chk("mul_ready_seen", 32'(nrdy), 32'd0);
            chk("mul_latency", 32'(k), 32'(W + 1));
            chk("mul_data", 32'(bus.resp_data), 32'hFFEB);
            chk("mul_nzp", 32'(bus.resp_nzp), 32'b100);
            bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
            @(negedge clk);
        end

        // Reset in the middle of an operation.
        @(negedge clk);
        bus.resp_ready = 1'b0; bus.req_valid = 1'b1;
        bus.req_op = 4'd7; bus.req_a = 16'h1234; bus.req_b = 16'h0005;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("prerst_busy", 32'(bus.busy), 32'(MUL_ON));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_valid", 32'(bus.resp_valid), 32'd0);
        chk("midrst_ready", 32'(bus.req_ready), 32'd1);
        chk("midrst_data", 32'(bus.resp_data), 32'd0);
        chk("midrst_nzp", 32'(bus.resp_nzp), 32'b010);
        rst = 1'b0;

        for (int i = 0; i < 300; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra = W'($urandom); rb = W'($urandom);
            run_op(rop, ra, rb, d, n, lat);
            chk($sformatf("rnd%0d_op%0d_data", i, rop), 32'(d),
                32'(ref_res(rop, ra, rb)));
            chk($sformatf("rnd%0d_nzp", i), 32'(n),
                32'(ref_nzp(ref_res(rop, ra, rb))));
            chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(ref_lat(rop)));
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lc3b_mc_alu.md
# lc3b_mc_alu

Parametrised multi-cycle ALU for the LC-3b datapath, generalising the single-cycle `lc3b_aluop` operation set to any power-of-two word width. It adds an iterative shift-add multiply and a registered valid/ready request/response handshake. Results are held until consumed, and the block also returns condition codes (nzp) for the result. It sits in the execute stage between operand select and the EX/MEM register, and stalls the pipeline through `req_ready` while a multiply iterates.

## Interface
- `WIDTH`, default 16: operand/result width; power of two, ≥ 4.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width; derived, not to be overridden.

- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready` at a rising edge.
- `req_op`  in  4  operation: 0 add, 1 and, 2 not, 3 pass, 4 sll, 5 srl, 6 sra, 7 mul, 8–15 reserved.
- `req_a`  in  WIDTH  operand A.
- `req_b`  in  WIDTH  operand B; shifts use `req_b[SHW-1:0]` only.
- `resp_valid`  out  1  result held and valid.
- `resp_ready`  in  1  consumer takes result when `resp_valid && resp_ready`.
- `resp_data`  out  WIDTH  result.
- `resp_nzp`  out  3  {n,z,p} of `resp_data` as signed; exactly one bit set while `resp_valid`.
- `busy`  out  1  high in MUL state.

## Operation
- FSM states: IDLE, MUL, DONE.
- **IDLE**:
  - `req_ready`=1.
  - On accept of a non-mul op, compute the result combinationally, register it into `resp_data`/`resp_nzp`, and go to DONE.
  - On accept of mul, load acc=0, mcand=`req_a`, mplier=`req_b`, cnt=0, and go to MUL.
- **MUL**, one multiplier bit per cycle:
  - If mplier[0], then acc += mcand (mod 2^WIDTH).
  - mcand <<= 1; mplier >>= 1; cnt++.
  - When cnt reaches WIDTH-1 in this cycle's update, write acc to `resp_data` and go to DONE.
  - The result is the low WIDTH bits of the unsigned product, which equals the low half of the signed product.
- **DONE**:
  - `resp_valid`=1.
  - `req_ready` = `resp_ready`, a combinational pass-through, so a new request can be accepted in the same cycle the response is consumed.
  - On `resp_ready`: if a request is also accepted, process it exactly as in IDLE (next state DONE or MUL); otherwise go to IDLE.
  - Without `resp_ready`: hold `resp_data`/`resp_nzp` stable and ignore `req_valid`.
- **Operation semantics**:
  - add wraps modulo 2^WIDTH.
  - not = ~A; pass = A.
  - sll/srl are zero-filled; sra replicates A[WIDTH-1].
  - A shift by 0 returns A.
- Reserved ops (8–15) behave as pass with latency 1.
- Request inputs are sampled only on accept; changes while in MUL have no effect.

## Timing
- Reset values: state=IDLE, `req_ready`=1 (combinational from IDLE), `resp_valid`=0, `resp_data`=0, `resp_nzp`=3'b010, `busy`=0, acc/mcand/mplier/cnt=0.
- Reset mid-multiply: abandon the operation, and return all outputs to their reset values on the next edge. `rst` has priority over every transition.
- Non-mul latency: accept at edge N, `resp_valid`=1 after edge N (visible in cycle N+1).
- Mul latency: accept at edge N, `busy` in cycles N+1..N+WIDTH, `resp_valid` from cycle N+WIDTH+1.
- Throughput:
  - One non-mul op per cycle when `resp_ready` is held high.
  - One mul per WIDTH+1 cycles.
- `resp_valid` never deasserts without a `resp_ready` handshake, except on `rst`.

## Configuration
- Macro `LC3B_ALU_MUL_EN`:
  - Defined: op 7 is the iterative multiply; the MUL state, counter and accumulator exist.
  - Undefined: op 7 is reserved (pass, latency 1); the MUL state and its registers are not built; `busy` is tied 0.

## Test plan
- Reset, then with WIDTH=16 issue add A=16'h7FFF, B=16'h0001, `resp_ready`=1 -> cycle after accept: `resp_data`=16'h8000, `resp_nzp`=3'b100.
- sra A=16'h8010, B=16'h0004 -> 16'hF801, nzp=100. srl on the same operands -> 16'h0801, nzp=001. sll A=16'h0001, B=16'h001F -> 16'h8000 (only B[3:0]=15 is used).
- mul A=16'hFFFD (-3), B=16'h0007 -> `busy` for exactly 16 cycles, then `resp_data`=16'hFFEB, nzp=100. `req_ready`=0 throughout; requests presented meanwhile are not accepted.
- Back-to-back: stream and(16'h00F0, 16'h0F0F) then not(16'h0000) with `resp_ready`=1 -> responses 16'h0000 (nzp=010) then 16'hFFFF on consecutive cycles, with no bubble.
- Backpressure: hold `resp_ready`=0 for 5 cycles after a result -> `resp_data` stable and `req_ready`=0. Release -> the response is consumed and a pending request is accepted in that same cycle.
- Assert `rst` 5 cycles into a multiply -> next cycle `busy`=0, `resp_valid`=0, `req_ready`=1. Without `LC3B_ALU_MUL_EN`: op 7 with A=16'h1234 -> 16'h1234 after 1 cycle.
